plab4_net_router_input_unit: RTL and testbench
==============================================

# plab4_net_router_input_unit

Buffered, route-computing input unit for one router port in the plab4 ring network. It accepts messages through a val/rdy handshake and stores them in a parametrised-depth FIFO. For the head message it computes output-port requests, using either the fixed pass-through policy or bidirectional shortest-path routing. It dequeues the head when the switch allocator grants a requested port, and sits between an input channel and the router's switch allocator/crossbar.

## Interface
- p_router_id, 0, id of the router containing this unit
- p_num_routers, 8, routers on the ring (≥2)
- p_msg_nbits, 32, payload width stored per entry
- p_depth, 4, FIFO entries; power of two, ≥2
- p_route_mode, 0, 0 = pass-through (non-local → p_default_reqs), 1 = shortest-path bidirectional
- p_default_reqs, 3'b001, non-local request vector in mode 0
- c_dest_nbits, $clog2(p_num_routers), derived; not set externally
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-high
- domain  input  1  security domain label (L); all data/control ports below are labelled Domain domain
- in_val  input  1  input message valid
- in_rdy  output  1  unit can accept
- in_dest  input  c_dest_nbits  destination router id of input message
- in_msg  input  p_msg_nbits  input payload
- reqs  output  3  requests: [0] forward (id+1), [1] terminal, [2] backward (id-1)
- grants  input  3  one-hot grant from allocator
- out_msg  output  p_msg_nbits  head payload; valid whenever reqs ≠ 0
- count  output  $clog2(p_depth)+1  current occupancy

## Operation
- State: storage array of p_depth × {dest, msg}; wr_ptr, rd_ptr ($clog2(p_depth) bits, wrap naturally); count register.
- Enqueue: in_val && in_rdy → write at wr_ptr, wr_ptr+1.
- in_rdy = !reset && (count < p_depth); it does not depend on same-cycle dequeue (no full-bypass).
- Route of head (combinational from stored dest, count ≠ 0):
  - dest == p_router_id → 3'b010.
  - mode 0, non-local → p_default_reqs.
  - mode 1: fwd = (dest − p_router_id) mod p_num_routers, computed in c_dest_nbits+1 bits; fwd ≤ p_num_routers/2 (integer) → 3'b001, else 3'b100. Tie goes forward.
- count == 0 → reqs = 3'b000; out_msg don't-care. There is no empty-bypass.
- Dequeue: |(reqs & grants) → rd_ptr+1. Grant bits not in reqs are ignored. reqs and out_msg hold stable until dequeue.
- Simultaneous enqueue and dequeue: count unchanged, FIFO order preserved. At full only dequeue is possible. At empty only enqueue is possible.
- count: +1 on enqueue only, −1 on dequeue only, else held.

## Timing
- Reset (async, takes effect immediately): wr_ptr = rd_ptr = count = 0. Outputs: reqs = 000, in_rdy = 0 while reset is high, in_rdy = 1 first cycle after release. Storage is not cleared.
- Reset mid-operation discards all queued messages. No partial state survives.
- Latency: a message accepted on edge N appears as reqs/out_msg in the cycle after edge N, at the earliest.
- Throughput: one enqueue and one dequeue per cycle sustained.
- in_rdy deasserts in the cycle after the accept that makes count == p_depth. It reasserts in the cycle after the first dequeue from full.

## Test plan
- Local delivery: p_router_id = 2, mode 1, push dest = 2 msg = 0xA5 → next cycle reqs = 010, out_msg = 0xA5. Grant 010 → count returns to 0, reqs = 000.
- Shortest path: p_num_routers = 8, p_router_id = 2, mode 1, dests 5, 6, 7, 0 → reqs 001, 001 (tie), 100, 100. Repeat with mode 0 → all 001.
- Full/backpressure: p_depth = 4, no grants, push 5 messages with in_val held → exactly 4 accepted, count = 4, in_rdy = 0. Grant once → count = 3, in_rdy = 1 next cycle, 5th message accepted.
- Simultaneous: count = 2, enqueue and matching grant in the same cycle → count stays 2, dequeued message is the oldest.
- Wrap-around/order: stream 10 messages (msg = 0..9) with random grant stalls → out_msg order 0..9, no loss or duplication. A non-requested grant (e.g. 100 while reqs = 001) does not dequeue.
- Reset mid-op: count = 3, assert reset between edges → count = 0, reqs = 000 immediately. After release, in_rdy = 1 and the first new message is the first one dequeued.

Source files
------------

// File: rtl/plab4_net_router_input_unit.sv
// Input unit of a plab4 ring router: val/rdy FIFO for incoming messages plus
// route computation on the head entry, dequeued when the allocator grants a requested port.
module plab4_net_router_input_unit #(
  parameter int unsigned p_router_id    = 0,
  parameter int unsigned p_num_routers  = 8,
  parameter int unsigned p_msg_nbits    = 32,
  parameter int unsigned p_depth        = 4,
  parameter int unsigned p_route_mode   = 0,
  parameter logic [2:0]  p_default_reqs = 3'b001,
  localparam int unsigned c_dest_nbits  = $clog2(p_num_routers)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     domain,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [c_dest_nbits-1:0]  in_dest,
  input  logic [p_msg_nbits-1:0]   in_msg,
  output logic [2:0]               reqs,
  input  logic [2:0]               grants,
  output logic [p_msg_nbits-1:0]   out_msg,
  output logic [$clog2(p_depth):0] count
);

  localparam int unsigned c_ptr_nbits = $clog2(p_depth);
  localparam int unsigned c_cnt_nbits = c_ptr_nbits + 1;
  localparam int unsigned c_fwd_nbits = c_dest_nbits + 1;

  localparam logic [c_fwd_nbits-1:0]  c_num_routers = c_fwd_nbits'(p_num_routers);
  localparam logic [c_fwd_nbits-1:0]  c_router_id   = c_fwd_nbits'(p_router_id);
  localparam logic [c_fwd_nbits-1:0]  c_half_ring   = c_fwd_nbits'(p_num_routers / 2);
  localparam logic [c_dest_nbits-1:0] c_local_id    = c_dest_nbits'(p_router_id);
  localparam logic [c_cnt_nbits-1:0]  c_full_count  = c_cnt_nbits'(p_depth);

  // The domain label is carried for information-flow tagging only; no logic depends on it.
  logic unused_domain;
  assign unused_domain = domain;

  logic [c_dest_nbits-1:0] dest_q [p_depth];
  logic [p_msg_nbits-1:0]  msg_q  [p_depth];

  logic [c_ptr_nbits-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_nbits-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_nbits-1:0] count_q, count_d;

  logic                    enq;
  logic                    deq;
  logic [c_dest_nbits-1:0] head_dest;
  logic [c_fwd_nbits-1:0]  fwd_sum;
  logic [c_fwd_nbits-1:0]  fwd_dist;
  logic [2:0]              route;

  assign in_rdy = !reset && (count_q < c_full_count);
  assign enq    = in_val && in_rdy;

  assign head_dest = dest_q[rd_ptr_q];

  // Forward hop distance modulo the ring size; the extra bit keeps dest + N - id from overflowing.
  assign fwd_sum  = {1'b0, head_dest} + c_num_routers - c_router_id;
  assign fwd_dist = (fwd_sum >= c_num_routers) ? (fwd_sum - c_num_routers) : fwd_sum;

  always_comb begin
    route = p_default_reqs;
    if (head_dest == c_local_id) begin
      route = 3'b010;
    end else if (p_route_mode == 1) begin
      route = (fwd_dist <= c_half_ring) ? 3'b001 : 3'b100;
    end
  end

  assign reqs    = (count_q != '0) ? route : 3'b000;
  assign out_msg = msg_q[rd_ptr_q];
  assign count   = count_q;
  assign deq     = |(reqs & grants);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + c_ptr_nbits'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + c_ptr_nbits'(1);
    end
    if (enq && !deq) begin
      count_d = count_q + c_cnt_nbits'(1);
    end else if (deq && !enq) begin
      count_d = count_q - c_cnt_nbits'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is deliberately not reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (enq) begin
      dest_q[wr_ptr_q] <= in_dest;
      msg_q[wr_ptr_q]  <= in_msg;
    end
  end

endmodule

// File: tb/tb_plab4_net_router_input_unit.sv
// Directed + randomized bench for the router input unit; two instances (shortest-path and
// pass-through) share the input stimulus and are each tracked by a queue-based reference model.
module tb_plab4_net_router_input_unit;

  localparam int ID = 2;
  localparam int N  = 8;
  localparam int W  = 32;
  localparam int D  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         domain;
  logic         in_val;
  logic [2:0]   in_dest;
  logic [W-1:0] in_msg;
  logic [2:0]   grants;

  logic         in_rdy1, in_rdy0;
  logic [2:0]   reqs1, reqs0;
  logic [W-1:0] out_msg1, out_msg0;
  logic [2:0]   count1, count0;

  int checks = 0;
  int errors = 0;

  logic [34:0] q1[$];
  logic [34:0] q0[$];
  bit          track = 0;
  int          exp_next = 0;

  always #5 clk = ~clk;

  plab4_net_router_input_unit #(
    .p_router_id(ID), .p_num_routers(N), .p_msg_nbits(W), .p_depth(D),
    .p_route_mode(1), .p_default_reqs(3'b001)
  ) u_dut1 (
    .clk(clk), .reset(reset), .domain(domain), .in_val(in_val), .in_rdy(in_rdy1),
    .in_dest(in_dest), .in_msg(in_msg), .reqs(reqs1), .grants(grants),
    .out_msg(out_msg1), .count(count1)
  );

  plab4_net_router_input_unit #(
    .p_router_id(ID), .p_num_routers(N), .p_msg_nbits(W), .p_depth(D),
    .p_route_mode(0), .p_default_reqs(3'b001)
  ) u_dut0 (
    .clk(clk), .reset(reset), .domain(domain), .in_val(in_val), .in_rdy(in_rdy0),
    .in_dest(in_dest), .in_msg(in_msg), .reqs(reqs0), .grants(grants),
    .out_msg(out_msg0), .count(count0)
  );

  function automatic logic [2:0] route(int dest, int mode);
    int fwd;
    if (dest == ID) return 3'b010;
    if (mode == 0) return 3'b001;
    fwd = (dest - ID + N) % N;
    return (fwd <= N / 2) ? 3'b001 : 3'b100;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] head_route(int mode);
    if (mode == 1) return (q1.size() != 0) ? route(int'(q1[0][34:32]), 1) : 3'b000;
    return (q0.size() != 0) ? route(int'(q0[0][34:32]), 0) : 3'b000;
  endfunction

  // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
  task automatic step();
    bit enq1, enq0, deq1, deq0;
    @(negedge clk);
    chk("count1", 64'(count1), 64'(q1.size()));
    chk("in_rdy1", 64'(in_rdy1), 64'(q1.size() < D));
    chk("reqs1", 64'(reqs1), 64'(head_route(1)));
    if (q1.size() != 0) chk("out_msg1", 64'(out_msg1), 64'(q1[0][31:0]));
    chk("count0", 64'(count0), 64'(q0.size()));
    chk("in_rdy0", 64'(in_rdy0), 64'(q0.size() < D));
    chk("reqs0", 64'(reqs0), 64'(head_route(0)));
    if (q0.size() != 0) chk("out_msg0", 64'(out_msg0), 64'(q0[0][31:0]));
    enq1 = in_val && (q1.size() < D);
    enq0 = in_val && (q0.size() < D);
    deq1 = |(head_route(1) & grants);
    deq0 = |(head_route(0) & grants);
    if (track && deq1) begin
      chk("stream_order", 64'(out_msg1), 64'(exp_next));
      exp_next++;
    end
    @(posedge clk);
    if (deq1) void'(q1.pop_front());
    if (deq0) void'(q0.pop_front());
    if (enq1) q1.push_back({in_dest, in_msg});
    if (enq0) q0.push_back({in_dest, in_msg});
    #1;
  endtask

  task automatic push(int dest, int msg);
    in_val  = 1'b1;
    in_dest = 3'(dest);
    in_msg  = W'(msg);
    step();
    in_val  = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    in_val = 1'b0;
    while ((q1.size() != 0 || q0.size() != 0) && k < 60) begin
      case ($urandom_range(0, 2))
        0: grants = 3'b001;
        1: grants = 3'b010;
        default: grants = 3'b100;
      endcase
      step();
      k++;
    end
    grants = 3'b000;
    chk("drain_empty", 64'(q1.size() + q0.size()), 64'd0);
  endtask

  initial begin
    int sent;
    int cyc;
    bit acc;
    int r;
    reset   = 1'b1;
    domain  = 1'b0;
    in_val  = 1'b0;
    in_dest = '0;
    in_msg  = '0;
    grants  = 3'b000;

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_count", 64'(count1), 64'd0);
    chk("rst_reqs", 64'(reqs1), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy1), 64'd0);
    reset = 1'b0;
    step();

    // Local delivery
    push(2, 32'hA5);
    chk("local_reqs", 64'(reqs1), 64'b010);
    chk("local_msg", 64'(out_msg1), 64'hA5);
    grants = 3'b010;
    step();
    grants = 3'b000;
    chk("local_count", 64'(count1), 64'd0);
    chk("local_reqs_empty", 64'(reqs1), 64'd0);
    step();

    // Shortest-path vs pass-through routing
    push(5, 5); push(6, 6); push(7, 7); push(0, 0);
    chk("sp_head1", 64'(reqs1), 64'b001);
    chk("pt_head0", 64'(reqs0), 64'b001);
    grants = 3'b001; step();
    chk("sp_tie", 64'(reqs1), 64'b001);
    step();
    chk("sp_back7", 64'(reqs1), 64'b100);
    grants = 3'b100; step();
    chk("sp_back0", 64'(reqs1), 64'b100);
    drain();

    // Non-requested grant ignored
    push(5, 32'h55);
    grants = 3'b100; step(); step();
    chk("ignored_grant", 64'(count1), 64'd1);
    drain();

    // Full/backpressure
    for (int i = 0; i < 5; i++) begin
      in_val = 1'b1; in_dest = 3'd2; in_msg = W'(32'h100 + i);
      step();
    end
    chk("full_count", 64'(count1), 64'd4);
    chk("full_rdy", 64'(in_rdy1), 64'd0);
    grants = 3'b010; step();
    grants = 3'b000;
    chk("after_deq_count", 64'(count1), 64'd3);
    chk("after_deq_rdy", 64'(in_rdy1), 64'd1);
    step();
    in_val = 1'b0;
    chk("fifth_accepted", 64'(count1), 64'd4);
    drain();

    // Simultaneous enqueue/dequeue
    push(2, 32'h21); push(2, 32'h22);
    in_val = 1'b1; in_dest = 3'd2; in_msg = 32'h23; grants = 3'b010;
    step();
    in_val = 1'b0; grants = 3'b000;
    chk("simul_count", 64'(count1), 64'd2);
    chk("simul_head", 64'(out_msg1), 64'h22);
    drain();

    // Randomized stream with stalls
    track = 1; exp_next = 0; sent = 0; cyc = 0;
    while ((sent < 10 || q1.size() != 0) && cyc < 400) begin
      in_val  = (sent < 10);
      in_dest = 3'($urandom_range(0, N - 1));
      in_msg  = W'(sent);
      r = $urandom_range(0, 3);
      grants = (r == 0) ? 3'b000 : (r == 1) ? 3'b001 : (r == 2) ? 3'b100 : head_route(1);
      acc = in_val && (q1.size() < D);
      step();
      if (acc) sent++;
      cyc++;
    end
    track = 0;
    chk("stream_done", 64'(exp_next), 64'd10);
    drain();

    // Reset mid-operation
    push(6, 1); push(6, 2); push(6, 3);
    chk("pre_reset_count", 64'(count1), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("midrst_count", 64'(count1), 64'd0);
    chk("midrst_reqs", 64'(reqs1), 64'd0);
    chk("midrst_rdy", 64'(in_rdy1), 64'd0);
    q1.delete();
    q0.delete();
    reset = 1'b0;
    step();
    push(2, 32'hBEEF);
    chk("post_rst_msg", 64'(out_msg1), 64'hBEEF);
    chk("post_rst_count", 64'(count1), 64'd1);
    grants = 3'b010; step();
    grants = 3'b000; step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
